tap_window_monitor: RTL and testbench
=====================================

# tap_window_monitor

Downstream consumer of the 4-bit, three-stage enabled shift chain. It takes the chain's input and its three taps as one 4-sample window, registers the window sum, and tracks peak value and over-threshold alarms with hysteresis. It shares CLK, RST and Ce with the shift chain, so its window stays aligned with the chain's contents cycle for cycle.

## Interface
Parameters:
- DW, 4: sample width; must match the shift chain.
- HOLD, 2: number of consecutive evaluations needed to enter or leave alarm (≥1).
- CNTW, 8: alarm event counter width.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- Ce  in  1  shift enable; the same net that drives the shift chain.
- Din  in  DW  chain input (newest sample).
- Dout2  in  DW  stage-1 tap (second newest).
- Dout1  in  DW  stage-2 tap.
- Dout  in  DW  stage-3 tap (oldest).
- Thr  in  DW+2  alarm threshold, unsigned.
- Clr  in  1  synchronous clear of Peak and AlarmCnt.
- Sum  out  DW+2  registered window sum.
- Valid  out  1  Sum holds a full-window result.
- Alarm  out  1  high while the FSM is in ALARM.
- Peak  out  DW+2  maximum Sum since reset or Clr.
- AlarmCnt  out  CNTW  number of ALARM entries; saturates at all-ones.

## Operation
- Fill counter (2 bits): counts Ce edges and saturates at 3. While fill<3 the taps still hold reset zeros, not real samples.
- Update edge (upd) = Ce & (fill==3). On an update edge:
  - Sum <= Din+Dout2+Dout1+Dout, zero-extended to DW+2 bits. The maximum value (4×15=60) cannot overflow.
  - Valid <= 1.
- Valid is sticky until RST. Sum holds its value between update edges.
- Peak <= max(Peak, new Sum) on each update edge.
- Evaluation on each update edge: over = new Sum > Thr (strict compare). Thr is sampled on the same edge.
- FSM states:
  - FILL: reset state. Moves to RUN on the first update edge, and that edge is also evaluated.
  - RUN: hi_cnt counts consecutive over evaluations; a non-over evaluation zeroes it. When hi_cnt reaches HOLD, go to ALARM, zero hi_cnt, and increment AlarmCnt (saturating).
  - ALARM: lo_cnt counts consecutive non-over evaluations; an over evaluation zeroes it. When lo_cnt reaches HOLD, go to RUN and zero lo_cnt.
- Ce=0: every register holds, including fill, the FSM counters and Sum.
- Clr: Peak <= 0 and AlarmCnt <= 0, except that when Clr coincides with an update edge, Peak <= new Sum. Clr does not affect fill, the FSM, Sum or Valid.
  - Clr together with an ALARM entry leaves AlarmCnt = 1.

## Timing
- Reset values: Sum=0, Valid=0, Alarm=0, Peak=0, AlarmCnt=0, fill=0, state=FILL, hi_cnt=lo_cnt=0.
- RST takes effect immediately, without waiting for a clock edge. After release, Valid needs 4 new Ce edges.
- Latency: Sum, Peak and Valid are visible one cycle after the Ce edge that sampled Din.
- Alarm asserts on the HOLD-th consecutive over update edge and deasserts on the HOLD-th consecutive non-over update edge.
- Alarm and AlarmCnt change on the same edge.
- Non-contiguous Ce: intervening Ce=0 cycles do not break a consecutive count.

## Structure
- Shared package tap_mon_pkg holds:
  - the state enum {FILL, RUN, ALARM};
  - localparams DW_DEF=4 and SW = DW+2.
- One sub-module, tap_alarm_fsm, holds the hysteresis FSM plus hi/lo counters. Its inputs are upd and over; its outputs are Alarm and an entry pulse.
- The top module holds the fill counter, adder, Peak, AlarmCnt and the Clr logic.

## Test plan
- Fill and first window: RST, then Ce pulses with Din=1,2,3,4 into the chain. Valid must stay 0 for 3 edges, then Valid=1 with Sum=10 after the 4th edge.
- Enable gating: after the fill window, hold Ce=0 for 5 cycles while Din changes. Sum, Valid, Peak and state must be unchanged.
- Alarm with hysteresis: Thr=40, Din=15 continuously. The first evaluation (Sum=60) must not alarm; Alarm=1 and AlarmCnt=1 on the second. Then Din=0 gives sums 45, 30, 15: Alarm stays 1 at 45 and 30, and drops at 15.
- Glitch rejection: Din=5 steady (Sum=20). Thr=19 for one update edge, then Thr=63. Alarm must stay 0, hi_cnt must return to 0, and AlarmCnt=0.
- Clr collision: Peak=60, then Clr asserted on an update edge with new Sum=20. Required result: Peak=20, AlarmCnt=0, Valid=1.
- Async reset mid-alarm: in ALARM, pulse RST between clock edges. All outputs must read 0 before the next edge, and Valid must return only after 4 further Ce edges.

Source files
------------

// File: rtl/tap_mon_pkg.sv
// Shared types and defaults for the tap window monitor and its alarm FSM.
package tap_mon_pkg;

    localparam int DW_DEF = 4;
    localparam int SW     = DW_DEF + 2;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALARM = 2'd2
    } state_e;

endpackage

// File: rtl/tap_window_monitor_if.sv
// Window taps, threshold and clear in; sum, peak and alarm status out.
interface tap_window_monitor_if #(
    parameter int DW   = 4,
    parameter int CNTW = 8
);
    logic            Ce;
    logic [DW-1:0]   Din;
    logic [DW-1:0]   Dout2;
    logic [DW-1:0]   Dout1;
    logic [DW-1:0]   Dout;
    logic [DW+1:0]   Thr;
    logic            Clr;
    logic [DW+1:0]   Sum;
    logic            Valid;
    logic            Alarm;
    logic [DW+1:0]   Peak;
    logic [CNTW-1:0] AlarmCnt;

    modport master (
        output Ce, Din, Dout2, Dout1, Dout, Thr, Clr,
        input  Sum, Valid, Alarm, Peak, AlarmCnt
    );

    modport slave (
        input  Ce, Din, Dout2, Dout1, Dout, Thr, Clr,
        output Sum, Valid, Alarm, Peak, AlarmCnt
    );
endinterface

// File: rtl/tap_alarm_fsm.sv
// Hysteresis FSM: HOLD consecutive over evaluations enter ALARM, HOLD
// consecutive non-over evaluations leave it. Only update edges are evaluated.
module tap_alarm_fsm
    import tap_mon_pkg::*;
#(
    parameter int HOLD = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_upd,
    input  logic i_over,
    output logic o_alarm,
    output logic o_entry
);

    localparam int CW = $clog2(HOLD + 1);

    localparam logic [1:0] S_FILL  = ST_FILL;
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_ALARM = ST_ALARM;

    logic [1:0]    r_state;
    logic [CW-1:0] r_hi_cnt;
    logic [CW-1:0] r_lo_cnt;
    logic [CW-1:0] w_hi_inc;
    logic [CW-1:0] w_lo_inc;
    logic          w_entry;
    logic          w_exit;

    assign w_hi_inc = r_hi_cnt + CW'(1);
    assign w_lo_inc = r_lo_cnt + CW'(1);

    // Entry is decoded combinationally so the event counter bumps on the same edge Alarm rises.
    assign w_entry = i_upd && (r_state != S_ALARM) && i_over && (w_hi_inc == CW'(HOLD));
    assign w_exit  = i_upd && (r_state == S_ALARM) && !i_over && (w_lo_inc == CW'(HOLD));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_FILL;
            r_hi_cnt <= '0;
            r_lo_cnt <= '0;
        end else if (i_upd) begin
            if (r_state == S_ALARM) begin
                if (i_over) begin
                    r_lo_cnt <= '0;
                end else if (w_exit) begin
                    r_state  <= S_RUN;
                    r_lo_cnt <= '0;
                end else begin
                    r_lo_cnt <= w_lo_inc;
                end
            end else begin
                // FILL evaluates its first update edge exactly like RUN.
                if (!i_over) begin
                    r_state  <= S_RUN;
                    r_hi_cnt <= '0;
                end else if (w_entry) begin
                    r_state  <= S_ALARM;
                    r_hi_cnt <= '0;
                end else begin
                    r_state  <= S_RUN;
                    r_hi_cnt <= w_hi_inc;
                end
            end
        end
    end

    assign o_alarm = (r_state == S_ALARM);
    assign o_entry = w_entry;

endmodule

// File: rtl/tap_window_monitor.sv
// Sums the shift chain's 4-sample window once the chain is full, tracks the
// peak sum and counts alarm entries of the hysteresis FSM.
module tap_window_monitor
    import tap_mon_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int HOLD = 2,
    parameter int CNTW = 8
) (
    input logic                 CLK,
    input logic                 RST,
    tap_window_monitor_if.slave bus
);

    localparam int SUM_W = DW + 2;

    logic [1:0]       r_fill;
    logic [SUM_W-1:0] r_sum;
    logic             r_valid;
    logic [SUM_W-1:0] r_peak;
    logic [CNTW-1:0]  r_cnt;
    logic             w_upd;
    logic [SUM_W-1:0] w_sum;
    logic             w_over;
    logic             w_entry;
    logic             w_alarm;

    // Taps hold reset zeros until three Ce edges have shifted real samples in.
    assign w_upd  = bus.Ce && (r_fill == 2'd3);
    assign w_sum  = SUM_W'(bus.Din) + SUM_W'(bus.Dout2) + SUM_W'(bus.Dout1) + SUM_W'(bus.Dout);
    assign w_over = (w_sum > bus.Thr);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fill <= 2'd0;
        end else if (bus.Ce && (r_fill != 2'd3)) begin
            r_fill <= r_fill + 2'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sum   <= '0;
            r_valid <= 1'b0;
        end else if (w_upd) begin
            r_sum   <= w_sum;
            r_valid <= 1'b1;
        end
    end

    // Clr restarts peak tracking from the window being summed on the same edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_peak <= '0;
        end else if (bus.Clr) begin
            r_peak <= w_upd ? w_sum : '0;
        end else if (w_upd && (w_sum > r_peak)) begin
            r_peak <= w_sum;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (bus.Clr) begin
            r_cnt <= w_entry ? CNTW'(1) : '0;
        end else if (w_entry && (r_cnt != {CNTW{1'b1}})) begin
            r_cnt <= r_cnt + CNTW'(1);
        end
    end

    tap_alarm_fsm #(
        .HOLD (HOLD)
    ) u_fsm (
        .CLK     (CLK),
        .RST     (RST),
        .i_upd   (w_upd),
        .i_over  (w_over),
        .o_alarm (w_alarm),
        .o_entry (w_entry)
    );

    assign bus.Sum      = r_sum;
    assign bus.Valid    = r_valid;
    assign bus.Alarm    = w_alarm;
    assign bus.Peak     = r_peak;
    assign bus.AlarmCnt = r_cnt;

endmodule

// File: tb/tb_tap_window_monitor.sv
// Self-checking bench: directed scenarios plus random traffic against a
// sample-history reference model of the window monitor and its shift chain.
module tb_tap_window_monitor;

    localparam int DW   = 4;
    localparam int HOLD = 2;
    localparam int CNTW = 8;

    logic CLK;
    logic RST;

    int n_checks;
    int n_errors;

    // Reference model state: Ce edges seen, last three chain samples (newest first).
    int m_n;
    int m_hist[3];
    int m_sum;
    int m_peak;
    int m_cnt;
    int m_run;
    bit m_valid;
    bit m_alarm;

    tap_window_monitor_if #(.DW(DW), .CNTW(CNTW)) bus ();

    tap_window_monitor #(
        .DW   (DW),
        .HOLD (HOLD),
        .CNTW (CNTW)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_n = 0;
        m_sum = 0;
        m_peak = 0;
        m_cnt = 0;
        m_run = 0;
        m_valid = 1'b0;
        m_alarm = 1'b0;
        for (int i = 0; i < 3; i++) m_hist[i] = 0;
    endtask

    task automatic drive_taps();
        bus.Dout2 = 4'(m_hist[0]);
        bus.Dout1 = 4'(m_hist[1]);
        bus.Dout  = 4'(m_hist[2]);
    endtask

    task automatic model_step(input bit ce, input int din, input int thr, input bit clr);
        int s;
        bit over;
        bit entry;
        entry = 1'b0;
        if (ce && m_n == 3) begin
            s = din + m_hist[0] + m_hist[1] + m_hist[2];
            m_sum = s;
            m_valid = 1'b1;
            over = (s > thr);
            // m_run counts consecutive evaluations pointing away from the current alarm state.
            if (over != m_alarm) begin
                m_run++;
                if (m_run == HOLD) begin
                    m_alarm = over;
                    m_run = 0;
                    entry = over;
                end
            end else begin
                m_run = 0;
            end
            if (clr) begin
                m_peak = s;
                m_cnt = entry ? 1 : 0;
            end else begin
                if (s > m_peak) m_peak = s;
                if (entry && m_cnt < (1 << CNTW) - 1) m_cnt++;
            end
        end else if (clr) begin
            m_peak = 0;
            m_cnt = 0;
        end
        if (ce) begin
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = din;
            if (m_n < 3) m_n++;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".sum"},   int'(bus.Sum),      m_sum);
        check({tag, ".valid"}, int'(bus.Valid),    int'(m_valid));
        check({tag, ".alarm"}, int'(bus.Alarm),    int'(m_alarm));
        check({tag, ".peak"},  int'(bus.Peak),     m_peak);
        check({tag, ".cnt"},   int'(bus.AlarmCnt), m_cnt);
    endtask

    task automatic cycle(input string tag, input bit ce, input int din, input int thr, input bit clr);
        bus.Ce  = ce;
        bus.Din = 4'(din);
        bus.Thr = 6'(thr);
        bus.Clr = clr;
        @(posedge CLK);
        model_step(ce, din, thr, clr);
        #1;
        drive_taps();
        check_outputs(tag);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        RST = 1'b1;
        bus.Ce = 1'b0;
        bus.Din = '0;
        bus.Thr = '0;
        bus.Clr = 1'b0;
        drive_taps();
        #12;
        check_outputs("reset");
        RST = 1'b0;

        // Fill and first window.
        for (int i = 1; i <= 4; i++) begin
            cycle("fill", 1'b1, i, 63, 1'b0);
            if (i < 4) check("fill_valid_low", int'(bus.Valid), 0);
        end
        check("first_sum", int'(bus.Sum), 10);
        check("first_valid", int'(bus.Valid), 1);

        // Enable gating.
        for (int i = 0; i < 5; i++) cycle("gate", 1'b0, int'($urandom_range(15)), 0, 1'b0);
        check("gate_sum", int'(bus.Sum), 10);
        check("gate_peak", int'(bus.Peak), 10);

        // Alarm with hysteresis: fill chain with 15s, then evaluate at Thr=40.
        for (int i = 0; i < 3; i++) cycle("pre15", 1'b1, 15, 63, 1'b0);
        cycle("alm", 1'b1, 15, 40, 1'b0);
        check("alm_first_60", int'(bus.Alarm), 0);
        cycle("alm", 1'b1, 15, 40, 1'b0);
        check("alm_second_60", int'(bus.Alarm), 1);
        check("alm_cnt", int'(bus.AlarmCnt), 1);
        cycle("alm", 1'b1, 0, 40, 1'b0);
        check("alm_45", int'(bus.Alarm), 1);
        cycle("alm", 1'b1, 0, 40, 1'b0);
        check("alm_30", int'(bus.Alarm), 1);
        cycle("alm", 1'b1, 0, 40, 1'b0);
        check("alm_15_sum", int'(bus.Sum), 15);
        check("alm_15", int'(bus.Alarm), 0);

        // Clr collision on an update edge with new Sum=20.
        for (int i = 0; i < 3; i++) cycle("pre5", 1'b1, 5, 63, 1'b0);
        check("clr_peak_before", int'(bus.Peak), 60);
        cycle("clr", 1'b1, 5, 63, 1'b1);
        check("clr_peak", int'(bus.Peak), 20);
        check("clr_cnt", int'(bus.AlarmCnt), 0);
        check("clr_valid", int'(bus.Valid), 1);

        // Glitch rejection: one over evaluation, then a reset of the count.
        cycle("glitch", 1'b1, 5, 19, 1'b0);
        cycle("glitch", 1'b1, 5, 63, 1'b0);
        cycle("glitch", 1'b1, 5, 19, 1'b0);
        check("glitch_alarm", int'(bus.Alarm), 0);
        cycle("glitch", 1'b1, 5, 63, 1'b0);
        check("glitch_alarm2", int'(bus.Alarm), 0);
        check("glitch_cnt", int'(bus.AlarmCnt), 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle("rand",
                  ($urandom_range(3) != 0),
                  int'($urandom_range(15)),
                  int'($urandom_range(63)),
                  ($urandom_range(19) == 0));
        end

        // Alarm counter saturation.
        for (int i = 0; i < 270; i++) begin
            cycle("sat", 1'b1, 15, 0, 1'b0);
            cycle("sat", 1'b1, 15, 0, 1'b0);
            cycle("sat", 1'b1, 15, 63, 1'b0);
            cycle("sat", 1'b1, 15, 63, 1'b0);
        end
        check("sat_cnt", int'(bus.AlarmCnt), 255);

        // Async reset mid-alarm.
        for (int i = 0; i < 6; i++) cycle("pre_rst", 1'b1, 15, 40, 1'b0);
        check("pre_rst_alarm", int'(bus.Alarm), 1);
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        drive_taps();
        check_outputs("async_rst");
        check("async_rst_alarm", int'(bus.Alarm), 0);
        check("async_rst_valid", int'(bus.Valid), 0);
        #1;
        RST = 1'b0;
        cycle("refill", 1'b1, 1, 63, 1'b0);
        check("refill_valid1", int'(bus.Valid), 0);
        cycle("refill", 1'b0, 9, 63, 1'b0);
        cycle("refill", 1'b1, 2, 63, 1'b0);
        check("refill_valid2", int'(bus.Valid), 0);
        cycle("refill", 1'b0, 9, 63, 1'b0);
        cycle("refill", 1'b1, 3, 63, 1'b0);
        check("refill_valid3", int'(bus.Valid), 0);
        cycle("refill", 1'b1, 4, 63, 1'b0);
        check("refill_valid4", int'(bus.Valid), 1);
        check("refill_sum", int'(bus.Sum), 10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
